param_unlock_controller: RTL and testbench

//  Parametrised successor of the 4-bit serial unlock system.

---
 rtl/param_unlock_if.sv | 28 ++
 rtl/param_unlock_controller.sv | 151 +++++++++++++++
 tb/tb_param_unlock_controller.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_unlock_if.sv
// Parallel code port and status bundle for param_unlock_controller.
// master drives code/password strobes; slave returns ready and results.
interface param_unlock_if #(
  parameter int N  = 4,
  parameter int FW = 2
);
  logic [N-1:0]  p_data;
  logic          p_valid;
  logic          p_ready;
  logic          pwd_wr;
  logic [N-1:0]  pwd_wdata;
  logic          unlock;
  logic          pwd_incorrect;
  logic          locked_out;
  logic [FW-1:0] fail_cnt;

  modport master (
    output p_data, p_valid, pwd_wr, pwd_wdata,
    input  p_ready, unlock, pwd_incorrect,
    input  locked_out, fail_cnt
  );

  modport slave (
    input  p_data, p_valid, pwd_wr, pwd_wdata,
    output p_ready, unlock, pwd_incorrect,
    output locked_out, fail_cnt
  );
endinterface

// File: rtl/param_unlock_controller.sv
// Serial N-bit unlock: latches a code, checks it LSB-first against a
// stored password, counts consecutive failures and enforces lockout.
// Ports: clk, rst_n (sync, active low), bus (param_unlock_if.slave):
//   p_data/p_valid/p_ready code port, pwd_wr/pwd_wdata password write,
//   unlock/pwd_incorrect result pulses, locked_out level, fail_cnt.
module param_unlock_controller #(
  parameter int          N           = 4,
  parameter logic [N-1:0] PWD_INIT   = 4'b1101,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 16,
  parameter int          FW          = $clog2(MAX_FAIL + 1)
) (
  input logic           clk,
  input logic           rst_n,
  param_unlock_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  localparam logic [FW-1:0] FMAX  = FW'(MAX_FAIL);
  localparam logic [FW:0]   FMAX1 = (FW+1)'(MAX_FAIL);
  localparam logic [IW-1:0] ILAST = IW'(N - 1);
  localparam logic [TW-1:0] TLOAD = TW'(LOCK_CYCLES);
  localparam logic [TW-1:0] TONE  = TW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  pwd_q, pwd_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          mis_q, mis_d;
  logic          ses_q, ses_d;
  logic [FW-1:0] fc_q, fc_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          unl_q, unl_d;
  logic          inc_q, inc_d;

  logic          bit_mis;
  logic          mis_all;
  logic [FW:0]   fc_nx;
  logic          last_fail;

  assign bit_mis   = sh_q[0] ^ pwd_q[idx_q];
  assign mis_all   = mis_q | bit_mis;
  assign fc_nx     = {1'b0, fc_q} + (FW+1)'(1);
  assign last_fail = (fc_nx >= FMAX1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pwd_q   <= PWD_INIT;
      sh_q    <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      ses_q   <= 1'b0;
      fc_q    <= '0;
      tmr_q   <= '0;
      unl_q   <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pwd_q   <= pwd_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      ses_q   <= ses_d;
      fc_q    <= fc_d;
      tmr_q   <= tmr_d;
      unl_q   <= unl_d;
      inc_q   <= inc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pwd_d       = pwd_q;
    sh_d        = sh_q;
    idx_d       = idx_q;
    mis_d       = mis_q;
    ses_d       = ses_q;
    fc_d        = fc_q;
    tmr_d       = tmr_q;
    unl_d       = 1'b0;
    inc_d       = 1'b0;
    bus.p_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        // a write strobe holds off any code for this cycle
        bus.p_ready = !bus.pwd_wr;
        if (bus.pwd_wr) begin
          if (ses_q) begin
            pwd_d = bus.pwd_wdata;
            ses_d = 1'b0;
          end
        end else if (bus.p_valid) begin
          sh_d    = bus.p_data;
          mis_d   = 1'b0;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        sh_d  = sh_q >> 1;
        idx_d = idx_q + IW'(1);
        mis_d = mis_all;
        if (idx_q == ILAST) begin
          state_d = IDLE;
          if (!mis_all) begin
            unl_d = 1'b1;
            fc_d  = '0;
            ses_d = 1'b1;
          end else begin
            inc_d = 1'b1;
            ses_d = 1'b0;
            if (last_fail) begin
              fc_d    = FMAX;
              tmr_d   = TLOAD;
              state_d = LOCKOUT;
            end else begin
              fc_d = fc_nx[FW-1:0];
            end
          end
        end
      end

      LOCKOUT: begin
        tmr_d = tmr_q - TONE;
        if (tmr_q == TONE) begin
          state_d = IDLE;
          fc_d    = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.unlock        = unl_q;
  assign bus.pwd_incorrect = inc_q;
  assign bus.locked_out    = (state_q == LOCKOUT);
  assign bus.fail_cnt      = fc_q;

endmodule

// File: tb/tb_param_unlock_controller.sv
// Scoreboard bench for param_unlock_controller: a 4-bit/3-fail/16-cycle
// instance and an 8-bit/1-fail/1-cycle instance.
module tb_param_unlock_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_unlock_if #(.N(4), .FW(2)) ia ();
  param_unlock_if #(.N(8), .FW(1)) ib ();

  param_unlock_controller dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  param_unlock_controller #(
    .N           (8),
    .PWD_INIT    (8'hA5),
    .MAX_FAIL    (1),
    .LOCK_CYCLES (1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  typedef struct {
    bit unl;
    int fc;
    int cyc;
    bit rdy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_a = 0;
  int hs_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input string why);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // monitors: every result pulse must match the head of its queue
  always @(negedge clk) begin
    if (ia.unlock || ia.pwd_incorrect) begin
      chk("a_excl", 32'(ia.unlock & ia.pwd_incorrect), 0);
      if (qa.size() == 0) begin
        flag("a_spurious", "pulse with nothing expected");
      end else begin
        ea = qa.pop_front();
        chk("a_kind", 32'(ia.unlock), 32'(ea.unl));
        chk("a_fail_cnt", 32'(ia.fail_cnt), ea.fc);
        chk("a_pulse_cyc", cyc, ea.cyc);
        chk("a_ready_pulse", 32'(ia.p_ready), 32'(ea.rdy));
      end
    end
  end

  always @(negedge clk) begin
    if (ib.unlock || ib.pwd_incorrect) begin
      chk("b_excl", 32'(ib.unlock & ib.pwd_incorrect), 0);
      if (qb.size() == 0) begin
        flag("b_spurious", "pulse with nothing expected");
      end else begin
        eb = qb.pop_front();
        chk("b_kind", 32'(ib.unlock), 32'(eb.unl));
        chk("b_fail_cnt", 32'(ib.fail_cnt), eb.fc);
        chk("b_pulse_cyc", cyc, eb.cyc);
        chk("b_ready_pulse", 32'(ib.p_ready), 32'(eb.rdy));
      end
    end
  end

  task automatic send_a(input logic [3:0] code, input bit unl,
                        input int fc, input bit rdy);
    int n = 0;
    exp_t e;
    @(negedge clk);
    ia.p_data  = code;
    ia.p_valid = 1'b1;
    while (!ia.p_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ia.p_ready) begin
      flag("a_handshake", "p_ready never rose");
      ia.p_valid = 1'b0;
      return;
    end
    hs_a  = cyc + 1;
    e.unl = unl;
    e.fc  = fc;
    e.cyc = hs_a + 4;
    e.rdy = rdy;
    qa.push_back(e);
    @(posedge clk);
    #1;
    ia.p_valid = 1'b0;
    ia.p_data  = 4'($urandom);
  endtask

  task automatic send_b(input logic [7:0] code, input bit unl,
                        input int fc, input bit rdy);
    int n = 0;
    exp_t e;
    @(negedge clk);
    ib.p_data  = code;
    ib.p_valid = 1'b1;
    while (!ib.p_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ib.p_ready) begin
      flag("b_handshake", "p_ready never rose");
      ib.p_valid = 1'b0;
      return;
    end
    hs_b  = cyc + 1;
    e.unl = unl;
    e.fc  = fc;
    e.cyc = hs_b + 8;
    e.rdy = rdy;
    qb.push_back(e);
    @(posedge clk);
    #1;
    ib.p_valid = 1'b0;
    ib.p_data  = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0)
      flag("drain", "expected pulses never arrived");
  endtask

  // write strobe together with a valid code: the write must win
  task automatic wr_a(input logic [3:0] d);
    drain();
    @(negedge clk);
    ia.pwd_wr    = 1'b1;
    ia.pwd_wdata = d;
    ia.p_valid   = 1'b1;
    ia.p_data    = 4'b1101;
    #1;
    chk("a_wr_blocks_ready", 32'(ia.p_ready), 0);
    @(posedge clk);
    #1;
    ia.pwd_wr  = 1'b0;
    ia.p_valid = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    int rdy_seen;
    int h1;

    ia.p_data = '0; ia.p_valid = 1'b0;
    ia.pwd_wr = 1'b0; ia.pwd_wdata = '0;
    ib.p_data = '0; ib.p_valid = 1'b0;
    ib.pwd_wr = 1'b0; ib.pwd_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_rst_ready", 32'(ia.p_ready), 1);
    chk("a_rst_unlock", 32'(ia.unlock), 0);
    chk("a_rst_incorrect", 32'(ia.pwd_incorrect), 0);
    chk("a_rst_locked", 32'(ia.locked_out), 0);
    chk("a_rst_fail_cnt", 32'(ia.fail_cnt), 0);
    chk("b_rst_ready", 32'(ib.p_ready), 1);
    chk("b_rst_fail_cnt", 32'(ib.fail_cnt), 0);
    rst_n = 1'b1;

    // match, then two mismatches
    send_a(4'b1101, 1, 0, 1);
    send_a(4'b1100, 0, 1, 1);
    send_a(4'b1001, 0, 2, 1);

    // clear, then three wrong codes into lockout
    send_a(4'b1101, 1, 0, 1);
    send_a(4'b0000, 0, 1, 1);
    send_a(4'b0111, 0, 2, 1);
    send_a(4'b1111, 0, 3, 0);
    n = 0;
    while (!ia.locked_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a_lock_seen", 32'(ia.locked_out), 1);
    ia.p_data  = 4'b1101;
    ia.p_valid = 1'b1;
    cnt = 0;
    rdy_seen = 0;
    while (ia.locked_out && cnt < 100) begin
      cnt++;
      if (ia.p_ready) rdy_seen++;
      @(negedge clk);
    end
    ia.p_valid = 1'b0;
    chk("a_lock_len", cnt, 16);
    chk("a_lock_ready", rdy_seen, 0);
    chk("a_post_lock_fc", 32'(ia.fail_cnt), 0);
    send_a(4'b1101, 1, 0, 1);

    // password change after a successful unlock
    wr_a(4'b0110);
    send_a(4'b1101, 0, 1, 1);
    send_a(4'b0110, 1, 0, 1);

    // write without a fresh unlock is dropped
    send_a(4'b0000, 0, 1, 1);
    wr_a(4'b1111);
    send_a(4'b0110, 1, 0, 1);

    // reset in the second shift cycle discards the attempt
    send_a(4'b0000, 0, 1, 1);
    drain();
    @(negedge clk);
    ia.p_data  = 4'b0110;
    ia.p_valid = 1'b1;
    #1;
    chk("a_t5_ready", 32'(ia.p_ready), 1);
    @(posedge clk);
    #1;
    ia.p_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("a_t5_ready_after", 32'(ia.p_ready), 1);
    chk("a_t5_fail_cnt", 32'(ia.fail_cnt), 0);
    chk("a_t5_locked", 32'(ia.locked_out), 0);
    repeat (6) @(negedge clk);
    send_a(4'b1101, 1, 0, 1);

    // wide instance: 8-cycle latency, 1-cycle lockout, back-to-back
    send_b(8'hA5, 1, 0, 1);
    send_b(8'h00, 0, 1, 0);
    n = 0;
    while (!ib.locked_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_lock_seen", 32'(ib.locked_out), 1);
    cnt = 0;
    while (ib.locked_out && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("b_lock_len", cnt, 1);
    chk("b_post_lock_fc", 32'(ib.fail_cnt), 0);
    send_b(8'hA5, 1, 0, 1);
    h1 = hs_b;
    send_b(8'hA5, 1, 0, 1);
    // second handshake lands on the edge that ends the pulse cycle
    chk("b_b2b_gap", hs_b - h1, 9);

    drain();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
